branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of direct-mapped BHT/BTB entries (power of 2, 4..256).
REQ-002 SHALL have parameter CNT_W, default 32, width of the statistics counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port lookup_pc  input  32  PC of the instruction being fetched in IF.
REQ-006 SHALL have port pred_taken  output  1  prediction for lookup_pc.
REQ-007 SHALL have port pred_target  output  32  next fetch PC for lookup_pc.
REQ-008 SHALL have port update_valid  input  1  EX stage is resolving a branch this cycle.
REQ-009 SHALL have ports update_pc/update_target (input 32) and update_taken (input 1): resolved branch PC, target and outcome.
REQ-010 SHALL have ports update_pred_taken (input 1) and update_pred_target (input 32): the prediction carried down the pipe with that branch.
REQ-011 SHALL have port invalidate  input  1  clears every table entry.
REQ-012 SHALL have port mispredict  output  1  EX flush request.
REQ-013 SHALL have port correct_pc  output  32  redirect PC when mispredict=1.
REQ-014 SHALL have ports branch_cnt and miss_cnt  output  CNT_W  resolved-branch and mispredict counts.

Function
REQ-015 SHALL index with PC[IDX+1:2], where IDX=log2(ENTRIES), and tag with PC[31:IDX+2]; each entry holds valid, tag, 2-bit counter and 32-bit target.
REQ-016 SHALL implement lookup as purely combinational: hit = valid && tag match; pred_taken = hit && cnt[1]; pred_target = pred_taken ? entry target : pc4(lookup_pc).
REQ-017 SHALL compute pc4(x) as {x[31], x[30:0]+4}, preserving bit 31 and letting bits 30:0 wrap.
REQ-018 SHALL assert mispredict combinationally when update_valid && (update_taken != update_pred_taken || (update_taken && update_target != update_pred_target)).
REQ-019 SHALL drive correct_pc = update_taken ? update_target : pc4(update_pc).
REQ-020 SHALL, on an update hit with taken, increment the counter saturating at 11 and write the target.
REQ-021 SHALL, on an update hit with not taken, decrement the counter saturating at 00 and leave the target unchanged.
REQ-022 SHALL, on an update miss with taken, allocate or replace the entry: valid=1, new tag, cnt=10, target written.
REQ-023 SHALL, on an update miss with not taken, leave the table unchanged.
REQ-024 SHALL make table updates visible from the next cycle; a same-cycle lookup of the updated index sees the old contents (no bypass).
REQ-025 SHALL, when invalidate=1, clear all valid bits at the next edge; invalidate takes priority and a same-cycle update is discarded, but statistics still count it.
REQ-026 SHALL increment branch_cnt per update_valid, and miss_cnt per mispredict, registered one cycle after, each saturating at all-ones.

Reset
REQ-027 SHALL, on reset, asynchronously clear all valid bits, set all counters to 01, zero all targets and tags, and zero branch_cnt and miss_cnt.
REQ-028 SHALL drive pred_taken=0 and pred_target=pc4(lookup_pc) while reset is asserted; asserting reset mid-operation discards any in-flight update.

Structure
REQ-029 SHALL place counter encodings SNT=00, WNT=01, WT=10, ST=11, the ENTRIES default and the pc4 function in the shared package bp_pkg.
REQ-030 SHALL implement the table in flip-flops, not inferred RAM, to allow async reset; one sub-module, bp_sat_counter2, implements the 2-bit saturating counter.

Verification (ENTRIES=64)
REQ-031 SHALL cover: reset, lookup_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014; lookup 0x7FFFFFFC -> 0x00000000; lookup 0xFFFFFFFC -> 0x80000000.
REQ-032 SHALL cover: update pc=0x00400020, taken, target 0x00400100, pred_taken=0 -> mispredict=1, correct_pc=0x00400100; next cycle lookup 0x00400020 -> pred_taken=1, pred_target=0x00400100; miss_cnt=1, branch_cnt=1.
REQ-033 SHALL cover aliasing: after REQ-032, lookup 0x00400120 (same index 8, different tag) -> pred_taken=0; a taken update of 0x00400120 replaces the entry and 0x00400020 then misses.
REQ-034 SHALL cover hysteresis: allocated entry (10) + one not-taken -> 01, predict not taken; then taken, taken -> 11; one not-taken -> 10, still predict taken.
REQ-035 SHALL cover collisions: invalidate and a taken update in the same cycle -> all lookups not taken next cycle, branch_cnt incremented; lookup and update of the same index in one cycle -> lookup returns old prediction.
REQ-036 SHALL cover reset mid-run: reset pulsed between clock edges after REQ-032 -> pred_taken=0 immediately, counters read 0, and the next lookup of 0x00400020 predicts not taken.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings, table default size
// and the sequential-PC helper.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

  localparam int unsigned BpEntries = 64;

  // Bit 31 is preserved; only bits 30:0 advance and wrap.
  function automatic logic [31:0] pc4(input logic [31:0] x);
    return {x[31], x[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state logic of a 2-bit saturating branch counter.
module bp_sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else if (cnt_i != SNT) begin
      cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB with combinational lookup, EX-stage resolution and
// saturating statistics counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = BpEntries,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      lookup_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             update_valid,
  input  logic [31:0]      update_pc,
  input  logic [31:0]      update_target,
  input  logic             update_taken,
  input  logic             update_pred_taken,
  input  logic [31:0]      update_pred_target,
  input  logic             invalidate,
  output logic             mispredict,
  output logic [31:0]      correct_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned Idx  = $clog2(ENTRIES);
  localparam int unsigned TagW = 30 - Idx;

  logic            valid_q [ENTRIES];
  logic [TagW-1:0] tag_q   [ENTRIES];
  logic [1:0]      cnt_q   [ENTRIES];
  logic [31:0]     tgt_q   [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q, miss_cnt_q;

  logic [Idx-1:0]  lk_idx, up_idx;
  logic [TagW-1:0] lk_tag, up_tag;
  logic            lk_hit, up_hit;
  logic [1:0]      up_cnt_next;
  logic            wr_hit, wr_alloc;
  logic            unused_pc_bits;

  assign lk_idx = lookup_pc[Idx+1:2];
  assign lk_tag = lookup_pc[31:Idx+2];
  assign up_idx = update_pc[Idx+1:2];
  assign up_tag = update_pc[31:Idx+2];
  assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && cnt_q[lk_idx][1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : pc4(lookup_pc);

  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign mispredict = update_valid && ((update_taken != update_pred_taken) ||
                      (update_taken && (update_target != update_pred_target)));
  assign correct_pc = update_taken ? update_target : pc4(update_pc);

  // Invalidate wins over any same-cycle table write.
  assign wr_hit   = update_valid && !invalidate && up_hit;
  assign wr_alloc = update_valid && !invalidate && !up_hit && update_taken;

  bp_sat_counter2 u_sat_counter (
    .cnt_i   (cnt_q[up_idx]),
    .taken_i (update_taken),
    .cnt_o   (up_cnt_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= WNT;
        tgt_q[i]   <= '0;
      end
    end else if (invalidate) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (wr_alloc) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      cnt_q[up_idx]   <= WT;
      tgt_q[up_idx]   <= update_target;
    end else if (wr_hit) begin
      cnt_q[up_idx] <= up_cnt_next;
      if (update_taken) tgt_q[up_idx] <= update_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (update_valid && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (mispredict && (miss_cnt_q != '1))     miss_cnt_q   <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor: stimulus queues expected values,
// a negedge monitor pops and compares them.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc, update_target, update_pred_target;
  logic        update_taken, update_pred_taken;
  logic        invalidate;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] branch_cnt, miss_cnt;

  typedef enum int {SigPt, SigPtgt, SigMis, SigCpc, SigBc, SigMc} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES (64),
    .CNT_W   (32)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .lookup_pc          (lookup_pc),
    .pred_taken         (pred_taken),
    .pred_target        (pred_target),
    .update_valid       (update_valid),
    .update_pc          (update_pc),
    .update_target      (update_target),
    .update_taken       (update_taken),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .invalidate         (invalidate),
    .mispredict         (mispredict),
    .correct_pc         (correct_pc),
    .branch_cnt         (branch_cnt),
    .miss_cnt           (miss_cnt)
  );

  // Monitor: every queued expectation is due at the next falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sig)
        SigPt:   act = {31'd0, pred_taken};
        SigPtgt: act = pred_target;
        SigMis:  act = {31'd0, mispredict};
        SigCpc:  act = correct_pc;
        SigBc:   act = branch_cnt;
        default: act = miss_cnt;
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  task automatic cyc(input logic [31:0] lpc);
    @(posedge clk);
    #1;
    lookup_pc    = lpc;
    update_valid = 1'b0;
    invalidate   = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                     input logic ptk, input logic [31:0] ptgt);
    update_valid       = 1'b1;
    update_pc          = pc;
    update_target      = tgt;
    update_taken       = tk;
    update_pred_taken  = ptk;
    update_pred_target = ptgt;
  endtask

  task automatic chk(input string n, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic chk_lk(input string n, input logic pt, input logic [31:0] ptgt);
    chk({n, "_pt"}, SigPt, {31'd0, pt});
    chk({n, "_ptgt"}, SigPtgt, ptgt);
  endtask

  task automatic chk_cnt(input string n, input logic [31:0] bc, input logic [31:0] mc);
    chk({n, "_bc"}, SigBc, bc);
    chk({n, "_mc"}, SigMc, mc);
  endtask

  initial begin
    reset = 1'b1;
    lookup_pc = 32'h0040_0010;
    update_valid = 1'b0;
    update_pc = '0;
    update_target = '0;
    update_taken = 1'b0;
    update_pred_taken = 1'b0;
    update_pred_target = '0;
    invalidate = 1'b0;

    // Reset state and pc4 boundaries
    cyc(32'h0040_0010);
    chk_lk("rst_lk", 1'b0, 32'h0040_0014);
    chk_cnt("rst", 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(32'h0040_0010);
    chk_lk("lk_basic", 1'b0, 32'h0040_0014);
    chk("no_upd_mis", SigMis, 0);
    cyc(32'h7FFF_FFFC);
    chk_lk("lk_wrap30", 1'b0, 32'h0000_0000);
    cyc(32'hFFFF_FFFC);
    chk_lk("lk_wrap31", 1'b0, 32'h8000_0000);

    // Allocation on taken miss; same-cycle lookup sees old contents
    cyc(32'h0040_0020);
    upd(32'h0040_0020, 32'h0040_0100, 1'b1, 1'b0, 32'h0040_0024);
    chk("alloc_mis", SigMis, 1);
    chk("alloc_cpc", SigCpc, 32'h0040_0100);
    chk_lk("alloc_old", 1'b0, 32'h0040_0024);
    cyc(32'h0040_0020);
    chk_lk("alloc_new", 1'b1, 32'h0040_0100);
    chk_cnt("alloc", 1, 1);

    // Aliasing on index 8
    cyc(32'h0040_0120);
    chk_lk("alias_miss", 1'b0, 32'h0040_0124);
    cyc(32'h0040_0120);
    upd(32'h0040_0120, 32'h0040_0200, 1'b1, 1'b0, 32'h0040_0124);
    chk("alias_mis", SigMis, 1);
    chk("alias_cpc", SigCpc, 32'h0040_0200);
    cyc(32'h0040_0020);
    chk_lk("alias_evict", 1'b0, 32'h0040_0024);
    chk_cnt("alias", 2, 2);
    cyc(32'h0040_0120);
    chk_lk("alias_new", 1'b1, 32'h0040_0200);

    // Hysteresis: 10 -> 01 -> 10 -> 11 -> 10 -> 01
    cyc(32'h0040_0120);
    upd(32'h0040_0120, 32'h0040_0200, 1'b0, 1'b1, 32'h0040_0200);
    chk("hy_nt_mis", SigMis, 1);
    chk("hy_nt_cpc", SigCpc, 32'h0040_0124);
    cyc(32'h0040_0120);
    chk_lk("hy_01", 1'b0, 32'h0040_0124);
    chk_cnt("hy1", 3, 3);
    upd(32'h0040_0120, 32'h0040_0200, 1'b1, 1'b0, 32'h0040_0124);
    chk("hy_t1_mis", SigMis, 1);
    cyc(32'h0040_0120);
    chk_lk("hy_10", 1'b1, 32'h0040_0200);
    upd(32'h0040_0120, 32'h0040_0200, 1'b1, 1'b1, 32'h0040_0200);
    chk("hy_t2_mis", SigMis, 0);
    cyc(32'h0040_0120);
    chk_lk("hy_11", 1'b1, 32'h0040_0200);
    chk_cnt("hy2", 5, 4);
    upd(32'h0040_0120, 32'h0040_0200, 1'b0, 1'b1, 32'h0040_0200);
    chk("hy_nt2_mis", SigMis, 1);
    cyc(32'h0040_0120);
    chk_lk("hy_10b", 1'b1, 32'h0040_0200);
    upd(32'h0040_0120, 32'h0040_0200, 1'b0, 1'b1, 32'h0040_0200);
    cyc(32'h0040_0120);
    chk_lk("hy_01b", 1'b0, 32'h0040_0124);
    chk_cnt("hy3", 7, 6);

    // Target-only mispredict, then target rewrite on hit
    upd(32'h0040_0120, 32'h0040_0300, 1'b1, 1'b1, 32'h0040_0200);
    chk("tgt_mis", SigMis, 1);
    chk("tgt_cpc", SigCpc, 32'h0040_0300);
    cyc(32'h0040_0120);
    chk_lk("tgt_new", 1'b1, 32'h0040_0300);
    chk_cnt("tgt", 8, 7);

    // Invalidate wins over a same-cycle taken update, which is still counted
    invalidate = 1'b1;
    upd(32'h0040_0040, 32'h0040_0500, 1'b1, 1'b1, 32'h0040_0500);
    chk("inv_mis", SigMis, 0);
    cyc(32'h0040_0120);
    chk_lk("inv_old", 1'b0, 32'h0040_0124);
    chk_cnt("inv", 9, 7);
    cyc(32'h0040_0040);
    chk_lk("inv_upd", 1'b0, 32'h0040_0044);

    // Reset pulsed between edges
    cyc(32'h0040_0020);
    upd(32'h0040_0020, 32'h0040_0100, 1'b1, 1'b0, 32'h0040_0024);
    cyc(32'h0040_0020);
    chk_lk("pre_rst", 1'b1, 32'h0040_0100);
    chk_cnt("pre_rst", 10, 8);
    cyc(32'h0040_0020);
    chk_lk("mid_rst", 1'b0, 32'h0040_0024);
    chk_cnt("mid_rst", 0, 0);
    #1 reset = 1'b1;
    #5 reset = 1'b0;
    cyc(32'h0040_0020);
    chk_lk("post_rst", 1'b0, 32'h0040_0024);
    chk_cnt("post_rst", 0, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
